// File: rtl/line_clear_ctrl.sv
// Row-clear sequencer: scans the board bottom-up, drops full rows, compacts the rest
// downward and zero-fills the vacated top rows. Optional scoring under LINE_CLEAR_SCORE_EN.
module line_clear_ctrl #(
  parameter int ROWS  = 20,
  parameter int COLS  = 10,
  parameter int ROW_W = 5
) (
  input  logic             clka,
  input  logic             restart,
  input  logic             start,
  output logic [ROW_W-1:0] rd_addr,
  input  logic [COLS-1:0]  rd_data,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_addr,
  output logic [COLS-1:0]  wr_data,
  output logic             busy,
  output logic             done,
  output logic [ROW_W-1:0] lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [19:0]      score
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_FILL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ROW_W-1:0] LAST = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ZERO = '0;
  localparam logic [ROW_W-1:0] ONE  = ROW_W'(1);

  logic [2:0]       state;
  logic [ROW_W-1:0] src, dst, count;
  logic             full;
  logic [ROW_W-1:0] cnt_nxt;

  assign full    = &rd_data;
  assign cnt_nxt = full ? count + ONE : count;

`ifdef LINE_CLEAR_SCORE_EN
  logic [10:0] pts;
  logic [20:0] sum;

  always_comb begin
    pts = 11'd0;
    case (count)
      ROW_W'(0): pts = 11'd0;
      ROW_W'(1): pts = 11'd40;
      ROW_W'(2): pts = 11'd100;
      ROW_W'(3): pts = 11'd300;
      default:   pts = 11'd1200;
    endcase
    sum = {1'b0, score} + {10'd0, pts};
  end
`endif

  // Write strobes are registered: the decision made in CHECK/FILL appears on wr_* the next cycle.
  always_ff @(posedge clka) begin
    if (restart) begin
      state         <= S_IDLE;
      rd_addr       <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      src           <= '0;
      dst           <= '0;
      count         <= '0;
`ifdef LINE_CLEAR_SCORE_EN
      score         <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src           <= LAST;
            dst           <= LAST;
            count         <= '0;
            lines_cleared <= '0;
            rd_addr       <= LAST;
            busy          <= 1'b1;
            state         <= S_READ;
          end
        end
        S_READ: state <= S_CHECK;
        S_CHECK: begin
          count <= cnt_nxt;
          if (!full) begin
            wr_en   <= 1'b1;
            wr_addr <= dst;
            wr_data <= rd_data;
            if (dst != ZERO) dst <= dst - ONE;
          end
          if (src == ZERO) begin
            if (cnt_nxt != ZERO) begin
              state <= S_FILL;
            end else begin
              state         <= S_DONE;
              done          <= 1'b1;
              lines_cleared <= cnt_nxt;
            end
          end else begin
            src     <= src - ONE;
            rd_addr <= src - ONE;
            state   <= S_READ;
          end
        end
        S_FILL: begin
          wr_en   <= 1'b1;
          wr_addr <= dst;
          wr_data <= '0;
          if (dst == ZERO) begin
            state         <= S_DONE;
            done          <= 1'b1;
            lines_cleared <= count;
          end else begin
            dst <= dst - ONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
`ifdef LINE_CLEAR_SCORE_EN
          score <= sum[20] ? 20'hFFFFF : sum[19:0];
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: board memory model, expected write stream and timing
// derived from the clear rules, plus literal spot checks.
module tb_line_clear_ctrl;
  localparam int ROWS = 20, COLS = 10, ROW_W = 5;

  logic             clka = 1'b0;
  logic             restart, start;
  logic [ROW_W-1:0] rd_addr, wr_addr, lines_cleared;
  logic [COLS-1:0]  rd_data, wr_data;
  logic             wr_en, busy, done;
`ifdef LINE_CLEAR_SCORE_EN
  logic [19:0]      score;
`endif

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W)) dut (
    .clka(clka), .restart(restart), .start(start),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .lines_cleared(lines_cleared)
`ifdef LINE_CLEAR_SCORE_EN
    , .score(score)
`endif
  );

  always #5 clka = ~clka;

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] img [ROWS];
  logic [COLS-1:0] exp_mem [ROWS];
  bit              load;

  always @(posedge clka) begin
    rd_data <= (int'(rd_addr) < ROWS) ? mem[rd_addr] : '0;
    if (load) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= img[r];
    end else if (wr_en && int'(wr_addr) < ROWS) begin
      mem[wr_addr] <= wr_data;
    end
  end

  int checks = 0, failures = 0;
  int qa[$], qd[$];
  bit active = 0;
  int cyc, done_cyc, busy_end, done_seen, done_at, exp_lines;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Per-cycle compare: done/busy timing and each write against the expected stream.
  always @(negedge clka) begin
    if (active) begin
      cyc++;
      checks++;
      if (done !== (cyc == done_cyc)) begin
        failures++;
        $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, cyc == done_cyc);
      end
      checks++;
      if (busy !== (cyc <= busy_end)) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, cyc <= busy_end);
      end
      if (done === 1'b1) begin
        done_seen++;
        done_at = cyc;
      end
      if (wr_en !== 1'b0) begin
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0h exp=none", cyc, wr_addr, wr_data);
        end else begin
          int a, d;
          a = qa.pop_front();
          d = qd.pop_front();
          if (int'(wr_addr) != a || int'(wr_data) != d) begin
            failures++;
            $display("FAIL write cyc=%0d got=%0d:%0h exp=%0d:%0h", cyc, wr_addr, wr_data, a, d);
          end
        end
      end
    end
  end

  task automatic load_board();
    @(negedge clka) load = 1;
    @(negedge clka) load = 0;
  endtask

  // Expected result: non-full rows keep order and sink to the bottom, zeros fill the top.
  task automatic build_model();
    int d;
    d = ROWS - 1;
    exp_lines = 0;
    qa.delete(); qd.delete();
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (img[r] == {COLS{1'b1}}) exp_lines++;
      else begin
        qa.push_back(d); qd.push_back(int'(img[r]));
        exp_mem[d] = img[r];
        d--;
      end
    end
    for (int r = d; r >= 0; r--) begin
      qa.push_back(r); qd.push_back(0);
      exp_mem[r] = '0;
    end
    done_cyc = 2 * ROWS + exp_lines + 1;
    busy_end = done_cyc;
  endtask

  task automatic pulse_start();
    @(negedge clka) start = 1;
    @(posedge clka) #1 start = 0;
    cyc = 0; done_seen = 0; done_at = -1; active = 1;
  endtask

  task automatic run_pass(input string nm, input bit repulse);
    build_model();
    load_board();
    pulse_start();
    if (repulse) begin
      repeat (9) @(posedge clka);
      #1 start = 1;
      @(posedge clka) #1 start = 0;
    end
    for (int t = 0; t < 200 && done_seen == 0; t++) @(posedge clka);
    repeat (3) @(posedge clka);
    @(negedge clka);
    #1 active = 0;
    chk({nm, "_done_count"}, done_seen, 1);
    chk({nm, "_writes_left"}, qa.size(), 0);
    chk({nm, "_lines"}, int'(lines_cleared), exp_lines);
    for (int r = 0; r < ROWS; r++) chk($sformatf("%s_row%0d", nm, r), int'(mem[r]), int'(exp_mem[r]));
  endtask

`ifdef LINE_CLEAR_SCORE_EN
  int exp_score = 0;
  function automatic int pts(input int n);
    case (n)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction
  task automatic score_pass(input int nfull);
    for (int r = 0; r < ROWS; r++) img[r] = (r >= ROWS - nfull) ? {COLS{1'b1}} : COLS'(r);
    run_pass("score", 0);
    exp_score = exp_score + pts(nfull);
    if (exp_score > 20'hFFFFF) exp_score = 20'hFFFFF;
    chk("score_model", int'(score), exp_score);
  endtask
`endif

  initial begin
    restart = 1; start = 0; load = 0;
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    load_board();
    repeat (2) @(posedge clka);
    #1 restart = 0;
    @(negedge clka);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_lines", int'(lines_cleared), 0);

    // Empty board
    run_pass("empty", 0);
    chk("empty_done_at", done_at, 41);
    chk("empty_lines_lit", int'(lines_cleared), 0);

    // One full row at the bottom
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    img[19] = 10'h3FF; img[18] = 10'h001;
    run_pass("one", 0);
    chk("one_done_at", done_at, 42);
    chk("one_row19_lit", int'(mem[19]), 10'h001);
    chk("one_row0_lit", int'(mem[0]), 0);
    chk("one_lines_lit", int'(lines_cleared), 1);

    // Two interleaved full rows
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    img[19] = 10'h3FF; img[18] = 10'h155; img[17] = 10'h3FF; img[16] = 10'h2AA;
    img[5] = 10'h0F0;
    run_pass("two", 0);
    chk("two_row19_lit", int'(mem[19]), 10'h155);
    chk("two_row18_lit", int'(mem[18]), 10'h2AA);
    chk("two_row1_lit", int'(mem[1]), 0);
    chk("two_row0_lit", int'(mem[0]), 0);
    chk("two_lines_lit", int'(lines_cleared), 2);

    // All rows full, with a start re-pulse mid-pass
    for (int r = 0; r < ROWS; r++) img[r] = {COLS{1'b1}};
    run_pass("all", 1);
    chk("all_lines_lit", int'(lines_cleared), 20);
    chk("all_done_at", done_at, 61);

    // Restart during the 7th CHECK: only the first six write-backs may appear
    for (int r = 0; r < ROWS; r++) img[r] = COLS'(r + 1);
    load_board();
    qa.delete(); qd.delete();
    for (int r = ROWS - 1; r >= ROWS - 6; r--) begin
      qa.push_back(r); qd.push_back(r + 1);
    end
    done_cyc = -1; busy_end = 14;
    pulse_start();
    repeat (13) @(posedge clka);
    #1 restart = 1;
    @(posedge clka) #1 restart = 0;
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_wr_en", int'(wr_en), 0);
    chk("rstmid_lines", int'(lines_cleared), 0);
    chk("rstmid_done", int'(done), 0);
    repeat (60) @(posedge clka);
    @(negedge clka);
    #1 active = 0;
    chk("rstmid_writes_left", qa.size(), 0);
    chk("rstmid_done_seen", done_seen, 0);

`ifdef LINE_CLEAR_SCORE_EN
    chk("score_after_rst", int'(score), 0);
    score_pass(4);
    chk("score_1200", int'(score), 1200);
    score_pass(1);
    chk("score_1240", int'(score), 1240);
    for (int i = 0; i < 874; i++) score_pass(4);
    chk("score_sat", int'(score), 20'hFFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
